// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard / forwarding controller.
//   FWD_REG / FWD_WB / FWD_MEM : EX operand forwarding mux selects
//   state_t                    : memory-wait FSM states {RUN, WAIT}
//   REG_AW_DEF                 : default register address width
package pipe_hazard_ctrl_pkg;

    localparam int          REG_AW_DEF = 5;

    localparam logic [1:0]  FWD_REG    = 2'b00;
    localparam logic [1:0]  FWD_WB     = 2'b01;
    localparam logic [1:0]  FWD_MEM    = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding comparator (combinational).
//   i_src          : EX source register to be resolved
//   i_mem_regwrite : MEM stage writes a register
//   i_mem_rd       : MEM destination
//   i_wb_regwrite  : WB stage writes a register
//   i_wb_rd        : WB destination
//   o_sel          : FWD_MEM, FWD_WB or FWD_REG; MEM is the younger value so it wins
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_wb_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    output logic [1:0]        o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hardwired zero, so a write to it never produces data.
    assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_src);
    assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

    always_comb begin
        o_sel = FWD_REG;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-freeze controller for the 5-stage pipeline.
// Combines load-use detection, EX operand forwarding, taken-branch flush,
// multi-cycle data memory stall and a sticky memory-wait timeout flag.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   i_id_*                    : ID instruction qualifiers and source registers
//   i_ex_*                    : EX qualifiers, sources, destination, redirect
//   i_mem_*                   : MEM writeback qualifier, request, ready, dest
//   i_wb_regwrite, i_wb_rd    : WB writeback qualifier and destination
//   o_hold_*                  : freeze the corresponding pipeline register / PC
//   o_bubble_idex/_memwb      : load a NOP into that register
//   o_flush_ifid              : load a NOP into IF/ID
//   o_fwd_a, o_fwd_b          : EX operand forwarding selects
//   o_mem_err                 : sticky timeout flag, cleared only by rst
//   o_lu_stalls, o_mem_stalls, o_flushes : perf counters (HAZARD_PERF_CNT_EN only)
//
// Build option: define HAZARD_PERF_CNT_EN to add the three wrapping perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_id_valid,
    input  logic              i_id_uses_rs,
    input  logic              i_id_uses_rt,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_ex_valid,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_redirect,
    input  logic              i_mem_regwrite,
    input  logic              i_mem_req,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_ready,
    input  logic              i_wb_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    output logic              o_hold_pc,
    output logic              o_hold_ifid,
    output logic              o_hold_idex,
    output logic              o_hold_exmem,
    output logic              o_bubble_idex,
    output logic              o_bubble_memwb,
    output logic              o_flush_ifid,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  o_lu_stalls,
    output logic [CNT_W-1:0]  o_mem_stalls,
    output logic [CNT_W-1:0]  o_flushes,
`endif
    output logic              o_mem_err
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    logic       w_lu;
    logic       w_mw;
    logic       w_unused_ex_regwrite;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [7:0] w_wait_cnt_nxt;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    // EX regwrite does not affect any decision here (EX results forward from MEM).
    assign w_unused_ex_regwrite = i_ex_regwrite;

    // ---------------- forwarding ----------------
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src          (i_ex_rs),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_sel          (w_fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src          (i_ex_rt),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_sel          (w_fwd_b)
    );

    assign o_fwd_a = rst ? FWD_REG : w_fwd_a;
    assign o_fwd_b = rst ? FWD_REG : w_fwd_b;

    // ---------------- hazard detection ----------------
    assign w_lu = i_id_valid && i_ex_valid && i_ex_memread && (i_ex_rd != '0) &&
                  ((i_id_uses_rs && (i_ex_rd == i_id_rs)) ||
                   (i_id_uses_rt && (i_ex_rd == i_id_rt)));

    assign w_mw = i_mem_req && !i_mem_ready;

    // Memory wait freezes everything, so a redirect or load-use in the frozen
    // stages is simply re-evaluated once memory completes. A redirect makes the
    // ID instruction wrong-path, so its load-use is irrelevant.
    always_comb begin
        o_hold_pc      = 1'b0;
        o_hold_ifid    = 1'b0;
        o_hold_idex    = 1'b0;
        o_hold_exmem   = 1'b0;
        o_bubble_idex  = 1'b0;
        o_bubble_memwb = 1'b0;
        o_flush_ifid   = 1'b0;
        if (!rst) begin
            if (w_mw) begin
                o_hold_pc      = 1'b1;
                o_hold_ifid    = 1'b1;
                o_hold_idex    = 1'b1;
                o_hold_exmem   = 1'b1;
                o_bubble_memwb = 1'b1;
            end else if (i_ex_redirect) begin
                o_flush_ifid   = 1'b1;
                o_bubble_idex  = 1'b1;
            end else if (w_lu) begin
                o_hold_pc      = 1'b1;
                o_hold_ifid    = 1'b1;
                o_bubble_idex  = 1'b1;
            end
        end
    end

    // ---------------- memory-wait FSM and timeout ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_mw)        w_state_nxt = WAIT;
            WAIT:    if (i_mem_ready) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_wait_cnt_nxt = (r_wait_cnt == TIMEOUT_VAL) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == WAIT) begin
                r_wait_cnt <= w_wait_cnt_nxt;
                // Sticky: the pipeline keeps waiting, software inspects the flag.
                if (w_wait_cnt_nxt == TIMEOUT_VAL) begin
                    r_mem_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign o_mem_err = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [CNT_W-1:0] r_lu_stalls;
    logic [CNT_W-1:0] r_mem_stalls;
    logic [CNT_W-1:0] r_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_stalls  <= '0;
            r_mem_stalls <= '0;
            r_flushes    <= '0;
        end else begin
            if (w_mw) begin
                r_mem_stalls <= r_mem_stalls + 1'b1;
            end else if (i_ex_redirect) begin
                r_flushes    <= r_flushes + 1'b1;
            end else if (w_lu) begin
                r_lu_stalls  <= r_lu_stalls + 1'b1;
            end
        end
    end

    assign o_lu_stalls  = r_lu_stalls;
    assign o_mem_stalls = r_mem_stalls;
    assign o_flushes    = r_flushes;
`endif

endmodule
